// File: rtl/mmt_sync_edge_filter.sv
// Purpose: debounce an already-synchronized level, emit rise/fall pulses, count edges, hold the last edge for a consumer.
// Latency: level_out and pulses update on the edge that samples the FILTER_CYCLES-th consecutive new value.
// Backpressure: one-entry event register with valid/ready; an edge arriving while it is full and not drained is dropped and flagged.
//
// Ports:
//   clk, rst          - sole clock (rising edge), synchronous active-high reset
//   sync_in           - input level, already synchronized into clk
//   level_out         - filtered, registered level
//   rise_pulse        - one-cycle pulse on an accepted 0->1 change
//   fall_pulse        - one-cycle pulse on an accepted 1->0 change
//   evt_valid         - event holding register occupied
//   evt_ready         - consumer accepts the held event
//   evt_edge          - held event type (1 = rise, 0 = fall)
//   evt_overflow      - sticky: an event was dropped (cleared only by rst)
//   edge_count        - saturating count of accepted edges
module mmt_sync_edge_filter #(
    parameter int FILTER_CYCLES = 4,
    parameter bit RESET_VAL     = 1'b0,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_in,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_edge,
    output logic             evt_overflow,
    output logic [CNT_W-1:0] edge_count
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        QUAL_HI   = 2'd1,
        STABLE_HI = 2'd2,
        QUAL_LO   = 2'd3
    } state_t;

    // qcnt value at which the next confirming sample completes qualification
    localparam logic [7:0] QLAST  = 8'(FILTER_CYCLES - 1);
    localparam bit         SINGLE = (FILTER_CYCLES == 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] qcnt;
    logic [7:0] qcnt_nxt;
    logic       rise_acc;
    logic       fall_acc;
    logic       edge_acc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_VAL ? STABLE_HI : STABLE_LO;
            qcnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            qcnt  <= qcnt_nxt;
        end
    end

    // Next-state logic. Any sample disagreeing with the candidate level
    // drops straight back to the stable state, so qualification needs an
    // unbroken run of FILTER_CYCLES samples.
    always_comb begin
        state_nxt = state;
        qcnt_nxt  = qcnt;
        case (state)
            STABLE_LO: begin
                if (sync_in) begin
                    if (SINGLE) begin
                        state_nxt = STABLE_HI;
                        qcnt_nxt  = 8'd0;
                    end else begin
                        state_nxt = QUAL_HI;
                        qcnt_nxt  = 8'd1;
                    end
                end
            end
            QUAL_HI: begin
                if (sync_in) begin
                    if (qcnt == QLAST) begin
                        state_nxt = STABLE_HI;
                        qcnt_nxt  = 8'd0;
                    end else begin
                        qcnt_nxt  = qcnt + 8'd1;
                    end
                end else begin
                    state_nxt = STABLE_LO;
                    qcnt_nxt  = 8'd0;
                end
            end
            STABLE_HI: begin
                if (!sync_in) begin
                    if (SINGLE) begin
                        state_nxt = STABLE_LO;
                        qcnt_nxt  = 8'd0;
                    end else begin
                        state_nxt = QUAL_LO;
                        qcnt_nxt  = 8'd1;
                    end
                end
            end
            QUAL_LO: begin
                if (!sync_in) begin
                    if (qcnt == QLAST) begin
                        state_nxt = STABLE_LO;
                        qcnt_nxt  = 8'd0;
                    end else begin
                        qcnt_nxt  = qcnt + 8'd1;
                    end
                end else begin
                    state_nxt = STABLE_HI;
                    qcnt_nxt  = 8'd0;
                end
            end
            default: begin
                state_nxt = STABLE_LO;
                qcnt_nxt  = 8'd0;
            end
        endcase
    end

    // Output decode: an edge is accepted only when entering a stable state
    // from the opposite level; a failed qualification returning to its own
    // stable state is not an edge.
    always_comb begin
        rise_acc = (state_nxt == STABLE_HI) && ((state == STABLE_LO) || (state == QUAL_HI));
        fall_acc = (state_nxt == STABLE_LO) && ((state == STABLE_HI) || (state == QUAL_LO));
        edge_acc = rise_acc || fall_acc;
    end

    // Registered level, pulses and saturating edge counter
    always_ff @(posedge clk) begin
        if (rst) begin
            level_out  <= RESET_VAL;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            edge_count <= '0;
        end else begin
            rise_pulse <= rise_acc;
            fall_pulse <= fall_acc;
            if (rise_acc) begin
                level_out <= 1'b1;
            end else if (fall_acc) begin
                level_out <= 1'b0;
            end
            if (edge_acc && (edge_count != {CNT_W{1'b1}})) begin
                edge_count <= edge_count + CNT_W'(1);
            end
        end
    end

    // Event holding register. A same-cycle drain frees the slot for the
    // incoming edge, so only a full, undrained register drops an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid    <= 1'b0;
            evt_edge     <= 1'b0;
            evt_overflow <= 1'b0;
        end else if (edge_acc) begin
            if (!evt_valid || evt_ready) begin
                evt_valid <= 1'b1;
                evt_edge  <= rise_acc;
            end else begin
                evt_overflow <= 1'b1;
            end
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mmt_sync_edge_filter.md
MMT_SYNC_EDGE_FILTER -- requirements
Module: mmt_sync_edge_filter

Interface
REQ-001 The block SHALL use exactly one clock and a synchronous, active-high reset; there SHALL be no asynchronous set or reset path.
REQ-002 Parameter FILTER_CYCLES, default 4, legal range 1..255: consecutive equal samples required to accept a level change.
REQ-003 Parameter RESET_VAL, default 0: filtered level held in reset.
REQ-004 Parameter CNT_W, default 8, legal range 1..32: width of edge_count.
REQ-005 Port clk, input, 1 bit: sole clock, rising edge.
REQ-006 Port rst, input, 1 bit: synchronous active-high reset.
REQ-007 Port sync_in, input, 1 bit: level already synchronized into clk (output of mmt_sync_single).
REQ-008 Port level_out, output, 1 bit: filtered, registered level.
REQ-009 Port rise_pulse, output, 1 bit: one-cycle pulse when level_out goes 0->1.
REQ-010 Port fall_pulse, output, 1 bit: one-cycle pulse when level_out goes 1->0.
REQ-011 Port evt_valid, output, 1 bit: event holding register occupied.
REQ-012 Port evt_ready, input, 1 bit: consumer accepts the event.
REQ-013 Port evt_edge, output, 1 bit: held event type, 1 = rise, 0 = fall; meaningful only while evt_valid=1.
REQ-014 Port evt_overflow, output, 1 bit: sticky flag set when an event was dropped.
REQ-015 Port edge_count, output, CNT_W bits: saturating count of accepted edges.

Function
REQ-016 FSM states: STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO; qualification counter qcnt is 8 bits.
REQ-017 STABLE_LO with sync_in=1: if FILTER_CYCLES=1, go to STABLE_HI; otherwise go to QUAL_HI with qcnt<=1. With sync_in=0, stay.
REQ-018 QUAL_HI with sync_in=1: if qcnt=FILTER_CYCLES-1, go to STABLE_HI; otherwise qcnt<=qcnt+1. With sync_in=0, go to STABLE_LO with qcnt<=0 and no edge.
REQ-019 STABLE_HI and QUAL_LO SHALL mirror REQ-017 and REQ-018 with the polarity of sync_in inverted.
REQ-020 On entry to STABLE_HI, at the same edge: level_out<=1 and rise_pulse<=1 for exactly one cycle. Entry to STABLE_LO from QUAL_LO SHALL set level_out<=0 and fall_pulse<=1 symmetrically.
REQ-021 Latency: level_out and the pulse SHALL update at the clock edge that samples the FILTER_CYCLES-th consecutive new value.
REQ-022 rise_pulse and fall_pulse SHALL never be high in the same cycle; both SHALL be 0 in all cycles without an accepted edge.
REQ-023 On an accepted edge, edge_count SHALL increment by 1 and hold at all-ones once it saturates (no wrap).
REQ-024 Event load: on an accepted edge, if evt_valid=0 or (evt_valid=1 and evt_ready=1), then evt_valid<=1 and evt_edge<=edge type.
REQ-025 Event drop: on an accepted edge with evt_valid=1 and evt_ready=0, the new event SHALL be discarded, the held event kept unchanged, and evt_overflow<=1.
REQ-026 With no accepted edge, evt_valid=1 and evt_ready=1 SHALL clear evt_valid at that edge.
REQ-027 evt_ready while evt_valid=0 SHALL have no effect.
REQ-028 evt_overflow SHALL clear only on rst.

Reset
REQ-029 While rst=1 at a clock edge: state<=STABLE_HI if RESET_VAL=1, else STABLE_LO; qcnt<=0; level_out<=RESET_VAL; rise_pulse, fall_pulse, evt_valid, evt_overflow<=0; edge_count<=0.
REQ-030 rst SHALL override every other input, including mid-qualification and a pending event; no pulse SHALL be generated by reset itself.
REQ-031 On the first cycle after rst deasserts, sync_in may be X or random. With FILTER_CYCLES>=2, that single sample SHALL NOT cause an accepted edge unless the following samples confirm it.

Verification
REQ-032 FILTER_CYCLES=4, RESET_VAL=0: sync_in held at 1 from cycle 0 -> level_out=1 and rise_pulse=1 for one cycle at the 4th sampling edge; edge_count=1, evt_valid=1, evt_edge=1.
REQ-033 sync_in sequence 1,1,1,0,1,1,1,1 -> no edge after the first three samples; rise accepted at the 8th sample only; edge_count=1.
REQ-034 evt_ready=0 while a rise then a fall are accepted -> evt_edge stays 1, evt_overflow=1, edge_count=2. Then evt_ready=1 for one cycle -> evt_valid=0.
REQ-035 Accepted edge coincides with evt_valid=1 and evt_ready=1 -> evt_valid remains 1, holding the new edge type, and evt_overflow stays 0.
REQ-036 rst asserted at qcnt=2 in QUAL_HI -> next cycle: level_out=0, edge_count=0, evt_valid=0, with no pulse. Also FILTER_CYCLES=1 with a one-cycle 1 on sync_in -> rise then fall on consecutive edges; edge_count saturates at 255 after 300 edges (CNT_W=8).
